// File: rtl/debug_run_ctrl.sv
// debug_run_ctrl: run/halt/single-step sequencer feeding the CPU pipeline stall.
// Ports:
//   clk, rstn     clock, synchronous active-low reset
//   halt_req      debug halt level (breakpoint or debug switch)
//   step_btn      debounced step button level; rising edge requests a step
//   step_count    instructions released per step (0 behaves as 1)
//   commit_valid  one instruction retired this cycle
//   cpu_stall     freeze pipeline
//   halted        sequencer is in HALTED
//   stepping      sequencer is in STEP
//   steps_left    commits still owed to the current step
//   step_done     one-cycle pulse on normal step completion
//   step_timeout  sticky flag: a step stopped because nothing retired
module debug_run_ctrl #(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned WDOG_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             halt_req,
    input  logic             step_btn,
    input  logic [CNT_W-1:0] step_count,
    input  logic             commit_valid,
    output logic             cpu_stall,
    output logic             halted,
    output logic             stepping,
    output logic [CNT_W-1:0] steps_left,
    output logic             step_done,
    output logic             step_timeout
);

    localparam logic [WDOG_W-1:0] WDOG_MAX = '1;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_STEP   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   steps_left_q, steps_left_d;
    logic [WDOG_W-1:0]  wdog_q, wdog_d;
    logic               prev_btn_q, prev_btn_d;
    logic               cpu_stall_q, cpu_stall_d;
    logic               halted_q, halted_d;
    logic               stepping_q, stepping_d;
    logic               step_done_q, step_done_d;
    logic               step_timeout_q, step_timeout_d;

    logic               step_req;
    logic [WDOG_W-1:0]  wdog_inc;

    // Next state, counters and Moore outputs derived from the next state
    always_comb begin
        state_d        = state_q;
        steps_left_d   = steps_left_q;
        wdog_d         = wdog_q;
        prev_btn_d     = step_btn;
        step_done_d    = 1'b0;
        step_timeout_d = step_timeout_q;

        // prev_btn tracks the button in every state so a held button never re-fires
        step_req = step_btn & ~prev_btn_q;
        wdog_inc = (wdog_q == WDOG_MAX) ? wdog_q : wdog_q + WDOG_W'(1);

        unique case (state_q)
            ST_RUN: begin
                steps_left_d = '0;
                if (halt_req) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                // also flushes a count held over from a watchdog abort
                steps_left_d = '0;
                if (!halt_req) begin
                    state_d = ST_RUN;
                end else if (step_req) begin
                    state_d        = ST_STEP;
                    steps_left_d   = (step_count == '0) ? CNT_W'(1) : step_count;
                    wdog_d         = '0;
                    step_timeout_d = 1'b0;
                end
            end
            ST_STEP: begin
                if (!halt_req) begin
                    state_d      = ST_RUN;
                    steps_left_d = '0;
                end else if (commit_valid) begin
                    wdog_d = '0;
                    if (steps_left_q == CNT_W'(1)) begin
                        state_d      = ST_HALTED;
                        steps_left_d = '0;
                        step_done_d  = 1'b1;
                    end else if (steps_left_q != '0) begin
                        steps_left_d = steps_left_q - CNT_W'(1);
                    end
                end else begin
                    // expiry fires on the idle cycle that brings the count to its max
                    wdog_d = wdog_inc;
                    if (wdog_inc == WDOG_MAX) begin
                        state_d        = ST_HALTED;
                        step_timeout_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d      = ST_RUN;
                steps_left_d = '0;
            end
        endcase

        if (!halt_req) begin
            step_timeout_d = 1'b0;
        end

        cpu_stall_d = (state_d == ST_HALTED);
        halted_d    = (state_d == ST_HALTED);
        stepping_d  = (state_d == ST_STEP);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q        <= ST_RUN;
            steps_left_q   <= '0;
            wdog_q         <= '0;
            prev_btn_q     <= 1'b0;
            cpu_stall_q    <= 1'b0;
            halted_q       <= 1'b0;
            stepping_q     <= 1'b0;
            step_done_q    <= 1'b0;
            step_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            steps_left_q   <= steps_left_d;
            wdog_q         <= wdog_d;
            prev_btn_q     <= prev_btn_d;
            cpu_stall_q    <= cpu_stall_d;
            halted_q       <= halted_d;
            stepping_q     <= stepping_d;
            step_done_q    <= step_done_d;
            step_timeout_q <= step_timeout_d;
        end
    end

    assign cpu_stall    = cpu_stall_q;
    assign halted       = halted_q;
    assign stepping     = stepping_q;
    assign steps_left   = steps_left_q;
    assign step_done    = step_done_q;
    assign step_timeout = step_timeout_q;

endmodule

// File: doc/debug_run_ctrl.md
# debug_run_ctrl

Run/halt/single-step sequencer between the debug breakpoint unit and the CPU pipeline stall logic. Converts the debug halt level and the debounced step button into a pipeline stall, and releases the pipeline for exactly N committed instructions per step press. N comes from the switches. A commit watchdog keeps a step that never retires from hanging the board.

## Interface

Parameters:
- CNT_W, 8, width of step count and remaining-step counter
- WDOG_W, 16, width of commit watchdog counter; timeout after 2^WDOG_W-1 stepping cycles with no commit

Ports:
- clk  input  1  clock
- rstn  input  1  reset, synchronous, active-low
- halt_req  input  1  level; 1 = debug mode requested (breakpoint hit or debug switch)
- step_btn  input  1  debounced step button level; rising edge = step request
- step_count  input  CNT_W  instructions per step; 0 treated as 1
- commit_valid  input  1  one instruction retired this cycle (at most one per cycle)
- cpu_stall  output  1  freeze pipeline (registered)
- halted  output  1  state == HALTED
- stepping  output  1  state == STEP
- steps_left  output  CNT_W  remaining commits in the current step; 0 outside STEP
- step_done  output  1  one-cycle pulse when a step completes normally
- step_timeout  output  1  sticky; set on watchdog expiry, cleared on the next accepted step request or on halt_req deassert

## Operation

- The state register has three states: RUN, HALTED, STEP. All outputs are registered Moore outputs.
- RUN: cpu_stall=0.
  - halt_req=1 → HALTED.
  - Step presses are ignored.
- HALTED: cpu_stall=1.
  - halt_req=0 → RUN.
  - Else, on a step_btn rising edge → STEP.
    - steps_left loads max(step_count,1).
    - Watchdog clears.
    - step_timeout clears.
- STEP: cpu_stall=0.
  - On each commit_valid, steps_left decrements and the watchdog clears.
  - Cycles without a commit increment the watchdog.
  - Exit priority, highest first:
    - (1) halt_req=0 → RUN, steps_left→0.
    - (2) commit_valid with steps_left==1 → HALTED, steps_left→0, step_done=1 next cycle.
    - (3) watchdog == 2^WDOG_W-1 without a commit → HALTED, step_timeout→1, steps_left holds its remaining value, then →0 on the next cycle.
- Step edge detection: one register holds the previous step_btn. step_req = step_btn & ~prev.
  - prev updates every cycle in every state, so a button held across a state change does not fire.
- Step presses received in STEP or RUN are dropped. They are never queued.
- A commit_valid arriving in HALTED or RUN (pipeline drain) does not affect the counters.
- Arithmetic:
  - steps_left never underflows; decrement only when nonzero.
  - The watchdog saturates.
  - step_count==0 is treated as 1.
- Reset (any state, including mid-step):
  - state=RUN.
  - cpu_stall=0, halted=0, stepping=0, steps_left=0, step_done=0, step_timeout=0.
  - Watchdog=0, prev step_btn=0.

## Timing

- halt_req rising in RUN at cycle t → cpu_stall=1 at t+1. Instructions committing at t are not blocked.
- Step request at cycle t (HALTED) → stepping=1, cpu_stall=0 at t+1.
- Nth commit at cycle t → halted=1, cpu_stall=1, step_done=1 at t+1. step_done=0 at t+2.
  - The pipeline must honour cpu_stall in the same cycle, so at most N commits occur per step.
- halt_req falling at t in any state → cpu_stall=0 at t+1.
- Watchdog: expiry reached at cycle t → state HALTED, step_timeout=1 at t+1.
- Simultaneous events in STEP:
  - halt_req=0 together with the final commit → RUN; step_done stays 0.
  - Final commit together with watchdog max → normal completion; step_timeout stays 0.
  - A step_btn edge in the same cycle as step completion is dropped.

## Test plan

- Reset mid-STEP:
  - Stimulus: step_count=5, press, two commits, rstn=0 for one cycle.
  - Required response: all outputs 0, state RUN. A later step press with halt_req=0 has no effect.
- Single step:
  - Stimulus: halt_req=1 → HALTED. step_count=0, press, commit 3 cycles later.
  - Required response: cpu_stall 0 for exactly 4 cycles. step_done pulses once. halted=1. Exactly one commit counted.
- Multi step with back-to-back commits:
  - Stimulus: step_count=4, commit_valid held 1.
  - Required response: steps_left 4,3,2,1,0. halted one cycle after the 4th commit. A 5th commit in the stall cycle does not change counters.
- Held button:
  - Stimulus: step_btn held high across STEP→HALTED.
  - Required response: no second step. A release then re-press starts a new step.
- Watchdog:
  - Stimulus: WDOG_W=4, step with no commits.
  - Required response: halted at cycle 16 after the request. step_timeout=1. The next press clears step_timeout.
- Abort:
  - Stimulus: halt_req drops during STEP with steps_left=3.
  - Required response: RUN next cycle, cpu_stall=0, steps_left=0, no step_done.
